waw_scoreboard: RTL and testbench

- Sequential successor to the combinational clear-units decoder for the RV32IMF core.
- Keeps one in-flight destination entry per execution unit, covering both the integer and FP register files.
- Detects RAW hazards (stall) and WAW hazards (registered clear of the older writer) at issue.
- Drives a per-unit writeback-kill so that cleared results never reach the register files.
- Sits between the ID/EXE issue point and the MEM/WB writeback arbiter.

---
 rtl/waw_pkg.sv | 30 +++
 rtl/waw_entry_cmp.sv | 34 +++
 rtl/waw_scoreboard.sv | 186 ++++++++++++++++++
 tb/tb_waw_scoreboard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/waw_pkg.sv
// Shared types and helpers for the WAW/RAW destination scoreboard.
// One waw_entry_t is kept per execution unit; rd_match applies the
// "integer x0 never matches" rule used for both RAW and WAW checks.
package waw_pkg;

    localparam int unsigned RD_W_DEF = 5;
    localparam int unsigned SRC_NUM  = 3;

    typedef struct packed {
        logic                valid;
        logic [RD_W_DEF-1:0] rd;
        logic                fp;
        logic                cleared;
    } waw_entry_t;

    // Register-address comparison against an entry; integer x0 is never a match,
    // FP f0 is an ordinary register.
    function automatic logic rd_match(
        input waw_entry_t          entry,
        input logic [RD_W_DEF-1:0] rd,
        input logic                fp
    );
        logic same_reg;
        logic int_x0;
        same_reg = (entry.rd == rd) && (entry.fp == fp);
        int_x0   = !fp && (rd == '0);
        return same_reg && !int_x0;
    endfunction

endpackage

// File: rtl/waw_entry_cmp.sv
// Hazard comparators for a single scoreboard entry: one RAW match bit per
// issuing source and a WAW match against the issuing destination. Only live
// entries (valid and not cleared) can match; the WAW check ignores the entry
// belonging to the unit being issued to.
module waw_entry_cmp
    import waw_pkg::*;
#(
    parameter int unsigned RD_W = RD_W_DEF
) (
    input  waw_entry_t               entry_i,
    input  logic                     self_i,
    input  logic [SRC_NUM*RD_W-1:0]  rs_i,
    input  logic [SRC_NUM-1:0]       rs_used_i,
    input  logic [SRC_NUM-1:0]       rs_fp_i,
    input  logic [RD_W-1:0]          rd_i,
    input  logic                     rd_fp_i,
    input  logic                     rd_we_i,
    output logic [SRC_NUM-1:0]       raw_o,
    output logic                     waw_o
);

    logic live;

    // Per-source RAW matches and the destination WAW match for this entry.
    always_comb begin
        live = entry_i.valid & ~entry_i.cleared;
        for (int unsigned s = 0; s < SRC_NUM; s++) begin
            raw_o[s] = live & rs_used_i[s] &
                       rd_match(entry_i, rs_i[s*RD_W +: RD_W], rs_fp_i[s]);
        end
        waw_o = live & rd_we_i & ~self_i & rd_match(entry_i, rd_i, rd_fp_i);
    end

endmodule

// File: rtl/waw_scoreboard.sv
// Destination scoreboard for the RV32IMF issue stage. One in-flight entry per
// execution unit (integer and FP files). RAW hazards stall issue; WAW hazards
// mark the older writer as cleared and pulse clear_unit one cycle after issue,
// and wb_kill suppresses the cleared unit's writeback. In debug mode a WAW
// stalls issue instead of clearing.
// Optional build macro: WAW_PERF_CNT_EN adds perf_clr, waw_clear_cnt and
// raw_stall_cnt (32-bit saturating event counters).
module waw_scoreboard
    import waw_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 9,
    parameter int unsigned RD_W      = RD_W_DEF,
    parameter int unsigned UNIT_W    = $clog2(NUM_UNITS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     issue_valid,
    input  logic [UNIT_W-1:0]        issue_unit,
    input  logic [RD_W-1:0]          issue_rd,
    input  logic                     issue_rd_we,
    input  logic                     issue_rd_fp,
    input  logic [SRC_NUM*RD_W-1:0]  issue_rs,
    input  logic [SRC_NUM-1:0]       issue_rs_used,
    input  logic [SRC_NUM-1:0]       issue_rs_fp,
    output logic                     issue_ready,
    output logic                     raw_stall,
    input  logic [NUM_UNITS-1:0]     wb_valid,
    output logic [NUM_UNITS-1:0]     wb_kill,
    output logic [NUM_UNITS-1:0]     clear_unit,
    input  logic                     debug_on,
    input  logic                     flush,
    output logic [NUM_UNITS-1:0]     busy_map
`ifdef WAW_PERF_CNT_EN
    ,
    input  logic                     perf_clr,
    output logic [31:0]              waw_clear_cnt,
    output logic [31:0]              raw_stall_cnt
`endif
);

    waw_entry_t           entries_q [NUM_UNITS];
    waw_entry_t           entries_d [NUM_UNITS];
    logic [NUM_UNITS-1:0] clear_unit_q;
    logic [NUM_UNITS-1:0] clear_unit_d;

    logic [SRC_NUM-1:0]   raw_vec [NUM_UNITS];
    logic [NUM_UNITS-1:0] waw_vec;
    logic [NUM_UNITS-1:0] self_vec;
    logic [NUM_UNITS-1:0] valid_vec;
    logic [NUM_UNITS-1:0] cleared_vec;
    logic [NUM_UNITS-1:0] clr_set;

    logic raw_any;
    logic waw_hit;
    logic unit_ok;
    logic busy_sel;
    logic wb_sel;
    logic rd_is_x0;
    logic alloc;

    // Per-unit comparators and one-hot decode of the issuing unit.
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_cmp
        assign self_vec[g]    = (32'(issue_unit) == g);
        assign valid_vec[g]   = entries_q[g].valid;
        assign cleared_vec[g] = entries_q[g].cleared;

        waw_entry_cmp #(
            .RD_W (RD_W)
        ) u_cmp (
            .entry_i   (entries_q[g]),
            .self_i    (self_vec[g]),
            .rs_i      (issue_rs),
            .rs_used_i (issue_rs_used),
            .rs_fp_i   (issue_rs_fp),
            .rd_i      (issue_rd),
            .rd_fp_i   (issue_rd_fp),
            .rd_we_i   (issue_rd_we),
            .raw_o     (raw_vec[g]),
            .waw_o     (waw_vec[g])
        );
    end

    // Issue acceptance: RAW stall, target unit occupancy and debug-mode WAW hold.
    always_comb begin
        raw_any = 1'b0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            raw_any = raw_any | (|raw_vec[u]);
        end
        waw_hit  = |waw_vec;
        // Out-of-range unit indices decode to no unit and are never accepted.
        unit_ok  = |self_vec;
        busy_sel = |(valid_vec & self_vec);
        wb_sel   = |(wb_valid & self_vec);
        rd_is_x0 = ~issue_rd_fp & (issue_rd == '0);

        issue_ready = issue_valid & unit_ok & ~flush & ~raw_any &
                      ~(busy_sel & ~wb_sel) & ~(debug_on & waw_hit);
        alloc       = issue_ready & issue_rd_we & ~rd_is_x0;
        // A unit writing back this cycle keeps its result instead of being cleared.
        clr_set     = (alloc & ~debug_on) ? (waw_vec & ~wb_valid) : '0;
    end

    // Next-state entries: free on writeback, mark WAW victims, then allocate.
    always_comb begin
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            entries_d[u] = entries_q[u];
            if (wb_valid[u] && entries_q[u].valid) begin
                entries_d[u] = '0;
            end
            if (clr_set[u]) begin
                entries_d[u].cleared = 1'b1;
            end
            if (alloc && self_vec[u]) begin
                entries_d[u].valid   = 1'b1;
                entries_d[u].rd      = issue_rd;
                entries_d[u].fp      = issue_rd_fp;
                entries_d[u].cleared = 1'b0;
            end
            if (flush) begin
                entries_d[u] = '0;
            end
        end
        clear_unit_d = flush ? '0 : clr_set;
    end

    // Entry state and the registered clear pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                entries_q[u] <= '0;
            end
            clear_unit_q <= '0;
        end else begin
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                entries_q[u] <= entries_d[u];
            end
            clear_unit_q <= clear_unit_d;
        end
    end

    assign raw_stall  = raw_any;
    assign busy_map   = valid_vec;
    assign wb_kill    = valid_vec & cleared_vec;
    assign clear_unit = clear_unit_q;

`ifdef WAW_PERF_CNT_EN
    logic [31:0] waw_clear_cnt_q;
    logic [31:0] waw_clear_cnt_d;
    logic [31:0] raw_stall_cnt_q;
    logic [31:0] raw_stall_cnt_d;
    logic [31:0] clr_pop;
    logic [32:0] clr_sum;
    logic [32:0] raw_sum;

    // Saturating increments: clear pulses per cycle and stalled issue cycles.
    always_comb begin
        clr_pop = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            clr_pop = clr_pop + 32'(clear_unit_q[u]);
        end
        clr_sum = {1'b0, waw_clear_cnt_q} + {1'b0, clr_pop};
        raw_sum = {1'b0, raw_stall_cnt_q} + 33'(issue_valid & raw_any);
        waw_clear_cnt_d = clr_sum[32] ? '1 : clr_sum[31:0];
        raw_stall_cnt_d = raw_sum[32] ? '1 : raw_sum[31:0];
        if (perf_clr) begin
            waw_clear_cnt_d = '0;
            raw_stall_cnt_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waw_clear_cnt_q <= '0;
            raw_stall_cnt_q <= '0;
        end else begin
            waw_clear_cnt_q <= waw_clear_cnt_d;
            raw_stall_cnt_q <= raw_stall_cnt_d;
        end
    end

    assign waw_clear_cnt = waw_clear_cnt_q;
    assign raw_stall_cnt = raw_stall_cnt_q;
`endif

endmodule

// File: tb/tb_waw_scoreboard.sv
// Directed bench for waw_scoreboard: inputs driven on the falling edge,
// outputs sampled 1 time unit later, expected values hand-computed.
module tb_waw_scoreboard;

    localparam int unsigned NU = 9;

    logic          clk;
    logic          reset_n;
    logic          issue_valid;
    logic [3:0]    issue_unit;
    logic [4:0]    issue_rd;
    logic          issue_rd_we;
    logic          issue_rd_fp;
    logic [14:0]   issue_rs;
    logic [2:0]    issue_rs_used;
    logic [2:0]    issue_rs_fp;
    logic          issue_ready;
    logic          raw_stall;
    logic [NU-1:0] wb_valid;
    logic [NU-1:0] wb_kill;
    logic [NU-1:0] clear_unit;
    logic          debug_on;
    logic          flush;
    logic [NU-1:0] busy_map;
`ifdef WAW_PERF_CNT_EN
    logic          perf_clr;
    logic [31:0]   waw_clear_cnt;
    logic [31:0]   raw_stall_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    waw_scoreboard #(
        .NUM_UNITS (NU),
        .RD_W      (5)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_unit    (issue_unit),
        .issue_rd      (issue_rd),
        .issue_rd_we   (issue_rd_we),
        .issue_rd_fp   (issue_rd_fp),
        .issue_rs      (issue_rs),
        .issue_rs_used (issue_rs_used),
        .issue_rs_fp   (issue_rs_fp),
        .issue_ready   (issue_ready),
        .raw_stall     (raw_stall),
        .wb_valid      (wb_valid),
        .wb_kill       (wb_kill),
        .clear_unit    (clear_unit),
        .debug_on      (debug_on),
        .flush         (flush),
        .busy_map      (busy_map)
`ifdef WAW_PERF_CNT_EN
        ,
        .perf_clr      (perf_clr),
        .waw_clear_cnt (waw_clear_cnt),
        .raw_stall_cnt (raw_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        issue_unit    = 4'd0;
        issue_rd      = 5'd0;
        issue_rd_we   = 1'b0;
        issue_rd_fp   = 1'b0;
        issue_rs      = 15'd0;
        issue_rs_used = 3'b000;
        issue_rs_fp   = 3'b000;
        wb_valid      = '0;
        flush         = 1'b0;
`ifdef WAW_PERF_CNT_EN
        perf_clr      = 1'b0;
`endif
    endtask

    task automatic set_issue(input logic [3:0] u, input logic [4:0] rd, input logic fp,
                             input logic [14:0] rs, input logic [2:0] used, input logic [2:0] rsfp);
        issue_valid   = 1'b1;
        issue_unit    = u;
        issue_rd      = rd;
        issue_rd_we   = 1'b1;
        issue_rd_fp   = fp;
        issue_rs      = rs;
        issue_rs_used = used;
        issue_rs_fp   = rsfp;
    endtask

    task automatic next();
        @(negedge clk);
        idle();
    endtask

    initial begin
        reset_n  = 1'b0;
        debug_on = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        check_vec("rst_busy",  32'(busy_map),    32'h0);
        check_vec("rst_clear", 32'(clear_unit),  32'h0);
        check_vec("rst_kill",  32'(wb_kill),     32'h0);
        check_vec("rst_ready", 32'(issue_ready), 32'h0);
        reset_n = 1'b1;

        // WAW: unit2 x5 then unit4 x5 clears unit2.
        next(); set_issue(4'd2, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t1_rdy_u2", 32'(issue_ready), 32'd1);
        next(); set_issue(4'd4, 5'd5, 1'b0, {5'd0, 5'd2, 5'd1}, 3'b011, 3'b000); #1;
        check_vec("t1_busy_u2", 32'(busy_map), 32'h004);
        check_vec("t1_rdy_u4",  32'(issue_ready), 32'd1);
        check_vec("t1_noraw",   32'(raw_stall), 32'd0);
        check_vec("t1_noclr0",  32'(clear_unit), 32'h0);
        next(); #1;
        check_vec("t1_clr_pulse", 32'(clear_unit), 32'h004);
        check_vec("t1_busy_both", 32'(busy_map), 32'h014);
        next(); wb_valid = 9'h004; #1;
        check_vec("t1_clr_once", 32'(clear_unit), 32'h0);
        check_vec("t1_kill_u2",  32'(wb_kill), 32'h004);
        next(); set_issue(4'd0, 5'd6, 1'b0, {5'd0, 5'd0, 5'd5}, 3'b001, 3'b000); #1;
        check_vec("t1_busy_u4", 32'(busy_map), 32'h010);
        check_vec("t1_raw_x5",  32'(raw_stall), 32'd1);
        check_vec("t1_rdy_blk", 32'(issue_ready), 32'd0);
        next(); set_issue(4'd0, 5'd6, 1'b0, {5'd0, 5'd0, 5'd5}, 3'b001, 3'b000); wb_valid = 9'h010; #1;
        check_vec("t1_kill_u4", 32'(wb_kill), 32'h0);
        next(); #1;
        check_vec("t1_empty", 32'(busy_map), 32'h0);

        // RAW on FP f7 held until unit3 writes back.
        next(); set_issue(4'd3, 5'd7, 1'b1, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t2_rdy_u3", 32'(issue_ready), 32'd1);
        next(); set_issue(4'd5, 5'd8, 1'b1, {5'd0, 5'd1, 5'd7}, 3'b011, 3'b011); #1;
        check_vec("t2_raw_f7", 32'(raw_stall), 32'd1);
        check_vec("t2_rdy0",   32'(issue_ready), 32'd0);
        next(); set_issue(4'd5, 5'd8, 1'b0, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b000); issue_valid = 1'b0; #1;
        check_vec("t2_int_x7_nomatch", 32'(raw_stall), 32'd0);
        next(); set_issue(4'd5, 5'd8, 1'b1, {5'd0, 5'd1, 5'd7}, 3'b011, 3'b011); wb_valid = 9'h008; #1;
        check_vec("t2_raw_wbcyc", 32'(raw_stall), 32'd1);
        check_vec("t2_rdy_wbcyc", 32'(issue_ready), 32'd0);
        next(); set_issue(4'd5, 5'd8, 1'b1, {5'd0, 5'd1, 5'd7}, 3'b011, 3'b011); #1;
        check_vec("t2_raw_gone", 32'(raw_stall), 32'd0);
        check_vec("t2_rdy_go",   32'(issue_ready), 32'd1);
        next(); #1;
        check_vec("t2_busy_u5", 32'(busy_map), 32'h020);
        next(); wb_valid = 9'h020;
        next(); #1;
        check_vec("t2_empty", 32'(busy_map), 32'h0);

        // x0 never allocates; f0 is an ordinary register.
        next(); set_issue(4'd1, 5'd3, 1'b0, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t3_rdy_u1", 32'(issue_ready), 32'd1);
        next(); set_issue(4'd0, 5'd0, 1'b0, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t3_rdy_x0", 32'(issue_ready), 32'd1);
        next(); #1;
        check_vec("t3_busy_nox0", 32'(busy_map), 32'h002);
        check_vec("t3_noclr",     32'(clear_unit), 32'h0);
        next(); set_issue(4'd6, 5'd0, 1'b1, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t3_rdy_f0a", 32'(issue_ready), 32'd1);
        next(); set_issue(4'd0, 5'd0, 1'b1, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t3_rdy_f0b", 32'(issue_ready), 32'd1);
        next(); #1;
        check_vec("t3_clr_f0",  32'(clear_unit), 32'h040);
        check_vec("t3_busy_f0", 32'(busy_map), 32'h043);
        next(); wb_valid = 9'h043; #1;
        check_vec("t3_kill_u6", 32'(wb_kill), 32'h040);
        next(); #1;
        check_vec("t3_empty", 32'(busy_map), 32'h0);

        // Writeback beats a simultaneous WAW clear.
        next(); set_issue(4'd2, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000);
        next(); set_issue(4'd4, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000); wb_valid = 9'h004; #1;
        check_vec("t4_rdy",  32'(issue_ready), 32'd1);
        check_vec("t4_kill", 32'(wb_kill), 32'h0);
        next(); #1;
        check_vec("t4_noclr", 32'(clear_unit), 32'h0);
        check_vec("t4_busy",  32'(busy_map), 32'h010);
        next(); wb_valid = 9'h010;
        // Busy unit blocks issue; free+allocate on the same edge.
        next(); set_issue(4'd7, 5'd9, 1'b0, 15'd0, 3'b000, 3'b000);
        next(); set_issue(4'd7, 5'd11, 1'b0, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t4_busyblk", 32'(issue_ready), 32'd0);
        next(); set_issue(4'd7, 5'd10, 1'b0, 15'd0, 3'b000, 3'b000); wb_valid = 9'h080; #1;
        check_vec("t4_freealloc_rdy", 32'(issue_ready), 32'd1);
        next(); set_issue(4'd0, 5'd1, 1'b0, {5'd0, 5'd0, 5'd10}, 3'b001, 3'b000); issue_valid = 1'b0; #1;
        check_vec("t4_busy_u7", 32'(busy_map), 32'h080);
        check_vec("t4_raw_x10", 32'(raw_stall), 32'd1);
        next(); wb_valid = 9'h080;
        next(); #1;
        check_vec("t4_empty", 32'(busy_map), 32'h0);

        // Debug mode: WAW stalls rather than clears.
        debug_on = 1'b1;
        next(); set_issue(4'd2, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t5_rdy_u2", 32'(issue_ready), 32'd1);
        next(); set_issue(4'd4, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t5_hold", 32'(issue_ready), 32'd0);
        next(); set_issue(4'd4, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t5_noclr",  32'(clear_unit), 32'h0);
        check_vec("t5_hold2",  32'(issue_ready), 32'd0);
        next(); set_issue(4'd4, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000); wb_valid = 9'h004; #1;
        check_vec("t5_hold_wbcyc", 32'(issue_ready), 32'd0);
        next(); set_issue(4'd4, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000); #1;
        check_vec("t5_rdy_after", 32'(issue_ready), 32'd1);
        next(); #1;
        check_vec("t5_noclr2", 32'(clear_unit), 32'h0);
        check_vec("t5_busy",   32'(busy_map), 32'h010);
        debug_on = 1'b0;
        next(); wb_valid = 9'h010;
        next(); #1;
        check_vec("t5_empty", 32'(busy_map), 32'h0);

        // Flush with entries on units 0/1/3/5 and a WAW pending.
        next(); set_issue(4'd1, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000);
        next(); set_issue(4'd3, 5'd6, 1'b0, 15'd0, 3'b000, 3'b000);
        next(); set_issue(4'd5, 5'd7, 1'b0, 15'd0, 3'b000, 3'b000);
        next(); set_issue(4'd0, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000);
        next(); set_issue(4'd8, 5'd6, 1'b0, 15'd0, 3'b000, 3'b000); flush = 1'b1; #1;
        check_vec("t6_clr_u1",    32'(clear_unit), 32'h002);
        check_vec("t6_busy_pre",  32'(busy_map), 32'h02B);
        check_vec("t6_rdy_flush", 32'(issue_ready), 32'd0);
        next(); #1;
        check_vec("t6_busy_post", 32'(busy_map), 32'h0);
        check_vec("t6_noclr",     32'(clear_unit), 32'h0);

        // Asynchronous reset while a clear is being pulsed.
        next(); set_issue(4'd2, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000);
        next(); set_issue(4'd4, 5'd5, 1'b0, 15'd0, 3'b000, 3'b000);
        @(posedge clk); #2;
        check_vec("t7_busy_pre", 32'(busy_map), 32'h014);
        check_vec("t7_clr_pre",  32'(clear_unit), 32'h004);
        reset_n = 1'b0; #1;
        check_vec("t7_busy_rst", 32'(busy_map), 32'h0);
        check_vec("t7_clr_rst",  32'(clear_unit), 32'h0);
        check_vec("t7_kill_rst", 32'(wb_kill), 32'h0);
        next(); reset_n = 1'b1;
        next(); #1;
        check_vec("t7_busy_after", 32'(busy_map), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
